link_arbiter: RTL

//   Round-robin arbiter sharing one slave_fsm-style byte link among N master_fsm-style requesters.

---
 rtl/link_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link among N_MASTERS requesters.
// Grant is held for a whole burst (until a last=1 byte or a GAP timeout); all outputs are registered.
module link_arbiter #(
  parameter int N_MASTERS   = 2,
  parameter int DATA_W      = 8,
  parameter int GAP_TIMEOUT = 16,
  parameter int COUNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  input  logic [N_MASTERS-1:0]          m_last,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic                          s_req,
  output logic [DATA_W-1:0]             s_data,
  input  logic                          s_ack,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy,
  output logic [COUNT_W-1:0]            xfer_count
);

  localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SEND, HOLD, DROP, GAP} state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_g;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic                   r_last_q;
  logic [N_MASTERS-1:0]   r_m_ack;
  logic                   r_s_req;
  logic [DATA_W-1:0]      r_s_data;
  logic [N_MASTERS-1:0]   r_grant;
  logic                   r_busy;
  logic [COUNT_W-1:0]     r_xfer_count;

  logic [PTR_W-1:0]       w_pick;
  logic [PTR_W-1:0]       w_next_ptr;
  logic                   w_g_req;
  logic [DATA_W-1:0]      w_pick_data;
  logic [DATA_W-1:0]      w_g_data;
  logic                   w_gap_done;

  // First requester at or after ptr, scanning with wrap-around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [PTR_W-1:0]     ptr);
    logic [PTR_W-1:0] sel;
    logic [PTR_W:0]   sum;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_MASTERS)) sum = sum - (PTR_W+1)'(N_MASTERS);
      if (!found && req[sum[PTR_W-1:0]]) begin
        sel   = sum[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_pick      = rr_pick(m_req, r_rr_ptr);
  assign w_next_ptr  = (r_g == PTR_W'(N_MASTERS-1)) ? '0 : r_g + 1'b1;
  assign w_g_req     = m_req[r_g];
  assign w_pick_data = m_data[int'(w_pick)*DATA_W +: DATA_W];
  assign w_g_data    = m_data[int'(r_g)*DATA_W +: DATA_W];
  assign w_gap_done  = (r_gap_cnt == GAP_W'(GAP_TIMEOUT-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_g          <= '0;
      r_rr_ptr     <= '0;
      r_gap_cnt    <= '0;
      r_last_q     <= 1'b0;
      r_m_ack      <= '0;
      r_s_req      <= 1'b0;
      r_s_data     <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|m_req) begin
            r_g      <= w_pick;
            r_grant  <= N_MASTERS'(1) << w_pick;
            r_s_data <= w_pick_data;
            r_last_q <= m_last[w_pick];
            r_s_req  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= SEND;
          end
        end
        SEND: begin
          // A requester dropping m_req early does not abort the slave handshake.
          if (s_ack) begin
            r_m_ack <= r_grant;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!w_g_req) begin
            r_s_req <= 1'b0;
            r_state <= DROP;
          end
        end
        DROP: begin
          if (!s_ack) begin
            r_m_ack      <= '0;
            r_xfer_count <= r_xfer_count + 1'b1;
            if (r_last_q) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          // A request in the timeout cycle still continues the burst.
          if (w_g_req) begin
            r_s_data <= w_g_data;
            r_last_q <= m_last[r_g];
            r_s_req  <= 1'b1;
            r_state  <= SEND;
          end else if (w_gap_done) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ack      = r_m_ack;
  assign s_req      = r_s_req;
  assign s_data     = r_s_data;
  assign grant      = r_grant;
  assign busy       = r_busy;
  assign xfer_count = r_xfer_count;

endmodule
